// File: rtl/seq_mul4_pkg.sv
// Shared constants for the sequential shift-add multiplier: default operand
// width and the controller state encoding.
package seq_mul4_pkg;
   localparam int SIZE_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mul_add4.sv
// SIZE-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
module mul_add4
   import seq_mul4_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            ci,
   output logic [SIZE-1:0] s,
   output logic            co
);
   logic [SIZE:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < SIZE; i++) begin : g_fa
      assign s[i]      = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign co = w_c[SIZE];
endmodule

// File: rtl/seq_mul4.sv
// Sequential unsigned shift-add multiplier: one partial product per RUN cycle,
// product registered on the last iteration and flagged by a one-cycle done.
module seq_mul4
   import seq_mul4_pkg::*;
#(
   parameter int SIZE = SIZE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   output logic              busy,
   output logic              done,
   output logic [2*SIZE-1:0] p
);
   localparam int CW = $clog2(SIZE) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);

   state_t              r_state;
   logic [SIZE-1:0]     r_mcand;
   logic [SIZE-1:0]     r_mplr;
   logic [SIZE-1:0]     r_acc_hi;
   logic [CW-1:0]       r_cnt;
   logic                r_busy;
   logic                r_done;
   logic [2*SIZE-1:0]   r_p;

   logic [SIZE-1:0]     w_addend;
   logic [SIZE-1:0]     w_sum;
   logic                w_co;
   logic [2*SIZE:0]     w_cat;
   logic [2*SIZE-1:0]   w_shift;

   assign w_addend = r_mplr[0] ? r_mcand : '0;

   mul_add4 #(.SIZE(SIZE)) u_add (
      .a  (r_acc_hi),
      .b  (w_addend),
      .ci (1'b0),
      .s  (w_sum),
      .co (w_co)
   );

   // Carry-out re-enters at the top as the concatenation shifts right by one.
   assign w_cat   = {w_co, w_sum, r_mplr};
   assign w_shift = w_cat[2*SIZE:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_acc_hi <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_p      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mcand  <= a;
                  r_mplr   <= b;
                  r_acc_hi <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               {r_acc_hi, r_mplr} <= w_shift;
               r_cnt              <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  r_p     <= w_shift;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign p    = r_p;
endmodule

// File: tb/tb_seq_mul4.sv
// Directed and randomized checks of seq_mul4 against an arithmetic product model.
module tb_seq_mul4;
   localparam int SIZE = 4;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [SIZE-1:0]   a;
   logic [SIZE-1:0]   b;
   logic              busy;
   logic              done;
   logic [2*SIZE-1:0] p;

   int n_tests = 0;
   int n_fail  = 0;
   logic [2*SIZE-1:0] exp_p;

   seq_mul4 #(.SIZE(SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge; leaves at the negedge where the next start may be driven.
   task automatic do_mul(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb, input bit pulse);
      logic [2*SIZE-1:0] old_p;
      logic [2*SIZE-1:0] new_p;
      old_p = exp_p;
      new_p = (2*SIZE)'(int'(ta) * int'(tb));
      start = 1'b1;
      a     = ta;
      b     = tb;
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j <= SIZE + 1; j++) begin
         check("busy", 16'(busy), 16'(j <= SIZE));
         check("done", 16'(done), 16'(j == SIZE));
         check("p",    16'(p),    16'((j >= SIZE) ? new_p : old_p));
         if (j <= SIZE) begin
            if (pulse && (j == 1 || j == SIZE)) begin
               start = 1'b1;
               a     = SIZE'(3);
               b     = SIZE'(3);
            end else begin
               start = 1'b0;
               a     = SIZE'($urandom);
               b     = SIZE'($urandom);
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      exp_p = new_p;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      exp_p = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 16'(busy), 16'(0));
      check("rst_done", 16'(done), 16'(0));
      check("rst_p",    16'(p),    16'(0));

      // Start accepted at the first rising edge after release.
      rst_n = 1'b1;
      do_mul(4'd15, 4'd15, 1'b0);
      check("p_225", 16'(p), 16'h00E1);

      do_mul(4'd7, 4'd9, 1'b0);
      check("p_63", 16'(p), 16'h003F);
      do_mul(4'd0, 4'd13, 1'b0);
      check("p_zero", 16'(p), 16'h0000);

      do_mul(4'd1, 4'd15, 1'b1);
      check("p_ign", 16'(p), 16'h000F);

      // Reset during RUN aborts immediately with no later done.
      start = 1'b1;
      a     = 4'd12;
      b     = 4'd10;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy", 16'(busy), 16'(1));
      rst_n = 1'b0;
      #1;
      check("arst_busy", 16'(busy), 16'(0));
      check("arst_done", 16'(done), 16'(0));
      check("arst_p",    16'(p),    16'(0));
      exp_p = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * SIZE; i++) begin
         @(negedge clk);
         check("post_rst_done", 16'(done), 16'(0));
         check("post_rst_busy", 16'(busy), 16'(0));
      end
      do_mul(4'd2, 4'd3, 1'b0);
      check("p_6", 16'(p), 16'h0006);

      for (int x = 0; x < (1 << SIZE); x++)
         for (int y = 0; y < (1 << SIZE); y++)
            do_mul(SIZE'(x), SIZE'(y), 1'b0);

      for (int r = 0; r < 40; r++)
         do_mul(SIZE'($urandom), SIZE'($urandom), 1'(($urandom) & 1));

      // Idle with start low: nothing moves.
      repeat (3) begin
         @(negedge clk);
         check("idle_done", 16'(done), 16'(0));
         check("idle_p",    16'(p),    16'(exp_p));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
